// File: rtl/uart_tx_fifo_engine.sv
// UART transmitter with DEPTH-entry TX FIFO, programmable baud divisor,
// 5..DATA_W data bits, five parity modes, 1/2 stop bits and level/ovf irq.
//
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   wr_en, wr_data  FIFO push (dropped and ovf set when full, no pop)
//   divisor         clocks per bit (0 -> 1)
//   data_len        data bits per frame (clamped to 5..DATA_W)
//   parity_mode     0 none, 1 even, 2 odd, 3 mark, 4 space, 5-7 none
//   stop2           two stop bits when set
//   thresh, irq_en  low-water interrupt level and enable
//   ovf_clr         clears sticky overflow
//   tx              registered serial output, idle high
//   txrdy, empty    FIFO not full / FIFO empty
//   level           FIFO occupancy 0..DEPTH
//   busy            frame in progress
//   ovf, irq        sticky overflow, interrupt request
module uart_tx_fifo_engine #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int DIV_W  = 19
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic [DIV_W-1:0]         divisor,
   input  logic [4:0]               data_len,
   input  logic [2:0]               parity_mode,
   input  logic                     stop2,
   input  logic [$clog2(DEPTH):0]   thresh,
   input  logic                     irq_en,
   input  logic                     ovf_clr,
   output logic                     tx,
   output logic                     txrdy,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     busy,
   output logic                     ovf,
   output logic                     irq
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
   localparam logic [4:0]    MAX_LEN  = 5'(DATA_W);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [LW-1:0]     count;
   logic              full;
   logic              push;
   logic              pop;

   logic [2:0]        state;
   logic [DIV_W-1:0]  tmr;
   logic [DIV_W-1:0]  div_q;
   logic [DIV_W-1:0]  div_cl;
   logic [DATA_W-1:0] sh;
   logic [4:0]        len_q;
   logic [4:0]        len_cl;
   logic [4:0]        bcnt;
   logic [2:0]        pm_q;
   logic              stop2_q;
   logic              par_acc;
   logic              par_bit;
   logic              has_par;
   logic              bit_done;
   logic              stop_end;
   logic              tx_q;
   logic              tx_nxt;

   assign full     = (count == FULL_LVL);
   assign bit_done = (tmr == div_q - DIV_W'(1));
   assign stop_end = (bcnt == {4'd0, stop2_q});
   assign has_par  = (pm_q >= 3'd1) && (pm_q <= 3'd4);

   // Pop when idle, or at the last stop-bit clock so the next start bit
   // follows with no idle gap.
   assign pop  = (count != '0) &&
                 ((state == S_IDLE) ||
                  (state == S_STOP && bit_done && stop_end));
   assign push = wr_en && (!full || pop);

   assign div_cl = (divisor == '0) ? DIV_W'(1) : divisor;

   always_comb begin
      len_cl = data_len;
      if (data_len < 5'd5)
         len_cl = 5'd5;
      else if (data_len > MAX_LEN)
         len_cl = MAX_LEN;
   end

   always_comb begin
      par_bit = 1'b1;
      case (pm_q)
         3'd1:    par_bit = par_acc;
         3'd2:    par_bit = ~par_acc;
         3'd4:    par_bit = 1'b0;
         default: par_bit = 1'b1;
      endcase
   end

   always_comb begin
      tx_nxt = 1'b1;
      case (state)
         S_START:  tx_nxt = 1'b0;
         S_DATA:   tx_nxt = sh[0];
         S_PARITY: tx_nxt = par_bit;
         default:  tx_nxt = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)
            count <= count + LW'(1);
         else if (pop && !push)
            count <= count - LW'(1);
         // A fresh overflow beats a simultaneous clear.
         if (wr_en && full && !pop)
            ovf <= 1'b1;
         else if (ovf_clr)
            ovf <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_IDLE;
         tmr     <= '0;
         div_q   <= DIV_W'(1);
         sh      <= '0;
         len_q   <= 5'd5;
         bcnt    <= '0;
         pm_q    <= '0;
         stop2_q <= 1'b0;
         par_acc <= 1'b0;
         tx_q    <= 1'b1;
      end else begin
         tx_q <= tx_nxt;
         if (pop) begin
            sh      <= mem[rd_ptr];
            len_q   <= len_cl;
            pm_q    <= parity_mode;
            stop2_q <= stop2;
            div_q   <= div_cl;
            par_acc <= 1'b0;
            bcnt    <= '0;
            tmr     <= '0;
            state   <= S_START;
         end else begin
            case (state)
               S_START: begin
                  if (bit_done) begin
                     tmr   <= '0;
                     bcnt  <= '0;
                     state <= S_DATA;
                  end else begin
                     tmr <= tmr + DIV_W'(1);
                  end
               end
               S_DATA: begin
                  if (bit_done) begin
                     tmr     <= '0;
                     sh      <= sh >> 1;
                     par_acc <= par_acc ^ sh[0];
                     if (bcnt == len_q - 5'd1) begin
                        bcnt  <= '0;
                        state <= has_par ? S_PARITY : S_STOP;
                     end else begin
                        bcnt <= bcnt + 5'd1;
                     end
                  end else begin
                     tmr <= tmr + DIV_W'(1);
                  end
               end
               S_PARITY: begin
                  if (bit_done) begin
                     tmr   <= '0;
                     bcnt  <= '0;
                     state <= S_STOP;
                  end else begin
                     tmr <= tmr + DIV_W'(1);
                  end
               end
               S_STOP: begin
                  if (bit_done) begin
                     tmr <= '0;
                     if (stop_end)
                        state <= S_IDLE;
                     else
                        bcnt <= bcnt + 5'd1;
                  end else begin
                     tmr <= tmr + DIV_W'(1);
                  end
               end
               default: begin
                  tmr <= '0;
               end
            endcase
         end
      end
   end

   assign tx    = tx_q;
   assign busy  = (state != S_IDLE);
   assign level = count;
   assign empty = (count == '0);
   assign txrdy = !full;
   assign irq   = irq_en & ((count <= thresh) | ovf);

endmodule

// File: tb/tb_uart_tx_fifo_engine.sv
// Self-checking bench for uart_tx_fifo_engine: directed cases plus
// randomized traffic decoded from the tx line against a frame model.
module tb_uart_tx_fifo_engine;

   localparam int DATA_W = 8;
   localparam int DEPTH  = 16;
   localparam int DIV_W  = 19;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              wr_en = 1'b0;
   logic [DATA_W-1:0] wr_data = '0;
   logic [DIV_W-1:0]  divisor = '0;
   logic [4:0]        data_len = '0;
   logic [2:0]        parity_mode = '0;
   logic              stop2 = 1'b0;
   logic [4:0]        thresh = '0;
   logic              irq_en = 1'b0;
   logic              ovf_clr = 1'b0;
   logic              tx;
   logic              txrdy;
   logic              empty;
   logic [4:0]        level;
   logic              busy;
   logic              ovf;
   logic              irq;

   uart_tx_fifo_engine #(
      .DATA_W(DATA_W), .DEPTH(DEPTH), .DIV_W(DIV_W)
   ) dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
      .divisor(divisor), .data_len(data_len),
      .parity_mode(parity_mode), .stop2(stop2), .thresh(thresh),
      .irq_en(irq_en), .ovf_clr(ovf_clr), .tx(tx), .txrdy(txrdy),
      .empty(empty), .level(level), .busy(busy), .ovf(ovf), .irq(irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] w;
      int          nb;
      int          div;
   } frame_t;

   frame_t exp_q[$];
   int n_chk = 0;
   int n_pass = 0;
   int mcnt = 0;
   int starts = 0;
   bit mon_on = 1'b0;
   bit mon_act = 1'b0;
   int run = 0;
   int last_run = 0;
   int p_div, p_len, p_pm;
   bit p_s2;
   logic smp [0:1023];

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic int eff_len(input int l);
      return (l < 5) ? 5 : ((l > DATA_W) ? DATA_W : l);
   endfunction

   function automatic int eff_div(input int d);
      return (d == 0) ? 1 : d;
   endfunction

   function automatic int frame_clks(input int d, input int l,
                                     input int pm, input bit s2);
      int p = (pm >= 1 && pm <= 4) ? 1 : 0;
      return eff_div(d) * (1 + eff_len(l) + p + (s2 ? 2 : 1));
   endfunction

   // Expected line bits in transmit order: bit k of the word is bit k.
   function automatic logic [31:0] frame_word(
      input logic [DATA_W-1:0] d, input int len, input int pm,
      input bit s2, output int nb);
      logic [31:0] w = '0;
      int k = 1;
      int ones = 0;
      for (int i = 0; i < len; i++) begin
         w[k] = d[i];
         ones += int'(d[i]);
         k++;
      end
      if (pm >= 1 && pm <= 4) begin
         if (pm == 1) w[k] = ones[0];
         else if (pm == 2) w[k] = ~ones[0];
         else w[k] = (pm == 3);
         k++;
      end
      w[k] = 1'b1;
      k++;
      if (s2) begin
         w[k] = 1'b1;
         k++;
      end
      nb = k;
      return w;
   endfunction

   task automatic apply_cfg(input int d, input int l, input int pm,
                            input bit s2);
      divisor = DIV_W'(d);
      data_len = 5'(l);
      parity_mode = 3'(pm);
      stop2 = s2;
      p_div = d;
      p_len = l;
      p_pm = pm;
      p_s2 = s2;
   endtask

   task automatic push(input logic [DATA_W-1:0] d, input bit track);
      frame_t f;
      wr_data = d;
      wr_en = 1'b1;
      @(posedge clk);
      #1;
      wr_en = 1'b0;
      if (track && mcnt < DEPTH) begin
         f.w = frame_word(d, eff_len(p_len), p_pm, p_s2, f.nb);
         f.div = eff_div(p_div);
         exp_q.push_back(f);
         mcnt++;
      end
   endtask

   task automatic wait_idle();
      int t = 0;
      while ((busy || !empty || exp_q.size() != 0 || mon_act) &&
             t < 50000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50000)
         chk("idle_timeout", 32'd1, 32'd0);
      @(negedge clk);
      #1;
   endtask

   task automatic wait_starts(input int n);
      int t = 0;
      while (starts < n && t < 5000) begin
         @(negedge clk);
         #1;
         t++;
      end
      if (t >= 5000)
         chk("start_timeout", 32'(starts), 32'(n));
   endtask

   always @(negedge clk) begin
      if (busy)
         run++;
      else begin
         if (run > 0)
            last_run = run;
         run = 0;
      end
   end

   // Line decoder: every cycle of every bit is sampled and compared.
   initial begin
      frame_t f;
      logic [31:0] obs;
      int gl;
      forever begin
         @(negedge clk);
         if (mon_on && !reset && tx === 1'b0) begin
            mon_act = 1'b1;
            starts++;
            mcnt--;
            if (exp_q.size() == 0) begin
               chk("unexpected_frame", 32'd1, 32'd0);
            end else begin
               f = exp_q.pop_front();
               smp[0] = tx;
               for (int i = 1; i < f.nb * f.div; i++) begin
                  @(negedge clk);
                  smp[i] = tx;
               end
               obs = '0;
               gl = 0;
               for (int k = 0; k < f.nb; k++)
                  obs[k] = smp[k * f.div + f.div / 2];
               for (int i = 0; i < f.nb * f.div; i++)
                  if (smp[i] !== smp[(i / f.div) * f.div + f.div / 2])
                     gl++;
               chk("frame_bits", obs, f.w);
               chk("frame_timing", 32'(gl), 32'd0);
            end
            mon_act = 1'b0;
         end
      end
   end

   initial begin
      int lat;
      int lows;
      int s0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_tx", 32'(tx), 32'd1);
      chk("rst_txrdy", 32'(txrdy), 32'd1);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      chk("rst_irq", 32'(irq), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      mon_on = 1'b1;

      // Basic frame, latency and frame length.
      apply_cfg(4, 8, 0, 0);
      last_run = 0;
      push(8'hA5, 1);
      lat = 0;
      while (tx !== 1'b0 && lat < 100) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      chk("start_latency", 32'(lat), 32'd2);
      wait_idle();
      chk("busy_len_a5", 32'(last_run), 32'd40);

      // Parity modes with 7 data bits and two stop bits.
      for (int pm = 1; pm <= 4; pm++) begin
         apply_cfg(3, 7, pm, 1);
         last_run = 0;
         push(8'h03, 1);
         wait_idle();
         chk("busy_len_par", 32'(last_run), 32'd33);
      end

      // Overflow, sticky flag, clear priority and gapless drain.
      apply_cfg(4, 8, 0, 0);
      thresh = 5'd2;
      irq_en = 1'b1;
      last_run = 0;
      push(8'h11, 1);
      for (int i = 1; i <= 16; i++)
         push(8'($urandom), 1);
      chk("full_level", 32'(level), 32'd16);
      chk("full_txrdy", 32'(txrdy), 32'd0);
      chk("full_no_ovf", 32'(ovf), 32'd0);
      push(8'hEE, 1);
      chk("ovf_set", 32'(ovf), 32'd1);
      chk("ovf_irq", 32'(irq), 32'd1);
      chk("ovf_level", 32'(level), 32'd16);
      ovf_clr = 1'b1;
      push(8'hDD, 1);
      ovf_clr = 1'b0;
      chk("ovf_clr_lose", 32'(ovf), 32'd1);
      ovf_clr = 1'b1;
      @(posedge clk);
      #1;
      ovf_clr = 1'b0;
      chk("ovf_cleared", 32'(ovf), 32'd0);
      chk("irq_after_clr", 32'(irq), 32'd0);
      wait_idle();
      chk("gapless_17", 32'(last_run),
          32'(17 * frame_clks(4, 8, 0, 0)));

      // Low-water interrupt.
      chk("irq_idle", 32'(irq), 32'd1);
      s0 = starts;
      for (int i = 0; i < 5; i++)
         push(8'($urandom), 1);
      chk("thr_level4", 32'(level), 32'd4);
      chk("thr_irq_lo", 32'(irq), 32'd0);
      wait_starts(s0 + 2);
      chk("thr_level3", 32'(level), 32'd3);
      chk("thr_irq_3", 32'(irq), 32'd0);
      wait_starts(s0 + 3);
      chk("thr_level2", 32'(level), 32'd2);
      chk("thr_irq_2", 32'(irq), 32'd1);
      irq_en = 1'b0;
      #1;
      chk("irq_disabled", 32'(irq), 32'd0);
      wait_idle();

      // Length clamps and zero divisor.
      apply_cfg(2, 3, 0, 0);
      push(8'h5A, 1);
      wait_idle();
      chk("len3_clks", 32'(last_run), 32'd14);
      apply_cfg(2, 20, 1, 0);
      push(8'hF1, 1);
      wait_idle();
      chk("len20_clks", 32'(last_run), 32'd22);
      apply_cfg(0, 8, 0, 0);
      push(8'h3C, 1);
      wait_idle();
      chk("div0_clks", 32'(last_run), 32'd10);

      // Configuration changed mid-frame applies to the next frame only.
      apply_cfg(3, 8, 0, 0);
      push(8'h96, 1);
      p_div = 2;
      p_len = 6;
      p_pm = 2;
      p_s2 = 1'b1;
      push(8'h2B, 1);
      apply_cfg(2, 6, 2, 1);
      wait_idle();
      chk("cfg_change_clks", 32'(last_run), 32'd50);

      // Randomized traffic.
      for (int ph = 0; ph < 6; ph++) begin
         wait_idle();
         apply_cfg($urandom_range(0, 5), $urandom_range(0, 31),
                   $urandom_range(0, 7), 1'($urandom_range(0, 1)));
         for (int c = 0; c < 300; c++) begin
            if ($urandom_range(0, 2) == 0 && mcnt < DEPTH)
               push(8'($urandom), 1);
            else begin
               @(posedge clk);
               #1;
            end
         end
      end
      wait_idle();
      chk("rand_no_ovf", 32'(ovf), 32'd0);

      // Reset mid-frame with entries queued.
      mon_on = 1'b0;
      apply_cfg(4, 8, 0, 0);
      for (int i = 0; i < 4; i++)
         push(8'($urandom), 0);
      repeat (10) @(posedge clk);
      #1;
      chk("pre_rst_busy", 32'(busy), 32'd1);
      chk("pre_rst_level", 32'(level), 32'd3);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk("mid_rst_tx", 32'(tx), 32'd1);
      chk("mid_rst_level", 32'(level), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      lows = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0)
            lows++;
      end
      chk("no_frames_after_rst", 32'(lows), 32'd0);
      chk("model_drained", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/uart_tx_fifo_engine.md
Name: uart_tx_fifo_engine

Overview:
- Parametrised UART transmitter for the tramelblaze UART subsystem, replacing the fixed 7/8-bit, single-buffer tx path.
- Contains a DEPTH-entry TX FIFO, a runtime-programmable baud divisor, data length 5..DATA_W, five parity modes and 1 or 2 stop bits.
- Also provides FIFO-level and overflow interrupt generation, driven from the processor port-decode logic in the UART top.

Parameters:
- DATA_W, 8, maximum data bits per frame; legal range 5..16.
- DEPTH, 16, TX FIFO entries; power of two, 2..256.
- DIV_W, 19, baud divisor width (clocks per bit).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; reset reset, synchronous, active-high
- wr_en  in  1  push wr_data into FIFO (one entry per cycle asserted)
- wr_data  in  DATA_W  character to send, LSB transmitted first
- divisor  in  DIV_W  clocks per bit; 0 treated as 1
- data_len  in  5  data bits per frame; <5 → 5, >DATA_W → DATA_W
- parity_mode  in  3  0 none, 1 even, 2 odd, 3 mark (1), 4 space (0), 5-7 none
- stop2  in  1  1 = two stop bits, 0 = one
- thresh  in  clog2(DEPTH)+1  low-water level for irq
- irq_en  in  1  interrupt enable
- ovf_clr  in  1  clears sticky overflow
- tx  out  1  serial line, idle high
- txrdy  out  1  FIFO not full
- empty  out  1  FIFO empty
- level  out  clog2(DEPTH)+1  FIFO occupancy 0..DEPTH
- busy  out  1  frame in progress
- ovf  out  1  sticky: write attempted while full
- irq  out  1  interrupt request

Behaviour:
- Reset values: tx=1, txrdy=1, empty=1, level=0, busy=0, ovf=0, irq=0; FIFO pointers cleared, FSM→IDLE.
- Reset mid-frame aborts the frame; tx=1 from the next cycle; queued data is discarded.
- FIFO write: wr_en && (!full || pop same cycle) stores wr_data at wr_ptr.
  - wr_en while full with no pop: data dropped, ovf set.
  - ovf_clr clears ovf; a new overflow in the same cycle wins (ovf stays 1).
- Pointers wrap modulo DEPTH. level = writes − pops, never exceeds DEPTH or underflows.
  - Simultaneous push and pop leaves level unchanged.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - If !empty: pop the head entry.
  - Latch the entry, clamped data_len, parity_mode, stop2 and divisor (0→1) into frame registers. Inputs changed mid-frame do not affect the current frame.
  - Go to START; busy=1.
- Bit timer: counts latched divisor clocks per bit; each bit lasts exactly divisor clocks.
- START: tx=0 for one bit time, then DATA.
- DATA:
  - Shifts out latched_len bits, LSB first.
  - Goes to PARITY if the parity mode is not none, else to STOP.
- PARITY:
  - even: XOR of the sent data bits.
  - odd: inverse of even.
  - mark: 1. space: 0.
- STOP: tx=1 for 1 or 2 bit times.
  - At the end: if FIFO non-empty, pop and go directly to START (no idle gap).
  - Otherwise go to IDLE with busy=0.
- Latency: wr_en sampled at edge N into an empty FIFO with FSM idle → pop at edge N+1, tx=0 from edge N+2.
- Frame length in clocks = divisor × (1 + len + P + S), where P ∈{0,1} and S ∈{1,2}.
- tx is driven from a register (glitch-free).
- Combinational status outputs:
  - txrdy = (level != DEPTH)
  - empty = (level == 0)
  - irq = irq_en & ((level <= thresh) | ovf)
- thresh ≥ DEPTH keeps the level term permanently true.

Test Plan:
- Reset, divisor=4, len=8, parity none, stop2=0, write 0xA5 → tx: start 0, bits 1,0,1,0,0,1,0,1, stop 1; each bit 4 clocks; busy high 40 clocks; tx low starts 2 clocks after write.
- len=7, parity even, stop2=1, divisor=3, write 0x03 → 7 data bits 1100000, parity 0, two stop bits; 33 clocks total. Repeat with odd → parity 1; mark → 1; space → 0.
- DEPTH=16: write 17 bytes back-to-back while FSM busy → txrdy drops at level 16, 17th byte dropped, ovf=1, irq=1 (irq_en=1); ovf_clr clears ovf; all 16 frames sent contiguously with no idle gap.
- thresh=2, irq_en=1, queue 5 bytes → irq low until level ≤2, then high; irq_en=0 forces irq=0.
- data_len=3 → frames use 5 bits; data_len=20 with DATA_W=8 → 8 bits. Divisor=0 → 1 clock per bit. Change divisor mid-frame → current frame keeps the old timing, next frame uses the new one.
- Assert reset during the DATA state of a frame with 3 bytes queued → tx=1 next cycle, level=0, busy=0, no further frames sent.
